// File: rtl/ecc_pkg.sv
// Shared definitions for the affine point-add unit: secp256k1 defaults and FSM encoding.
// Holds no logic, so it adds no latency and has no flow control.
package ecc_pkg;
   localparam int ECC_WIDTH = 256;
   localparam logic [255:0] ECC_FIELD_P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
   localparam logic [255:0] ECC_CURVE_A = 256'd0;

   typedef enum logic [3:0] {
      S_IDLE, S_CLASS, S_SHORT, S_NUM, S_DEN, S_INV,
      S_LAM, S_LSQ, S_X3, S_Y3M, S_Y3, S_DONE
   } state_e;
endpackage

// File: rtl/ecc_point_add_unit_if.sv
// Request/response bundle between the scalar-mult controller (master) and the point-add unit (slave).
// Strobe-only handshake with no backpressure; err exists only when ECC_ADD_ERR_EN is defined.
interface ecc_point_add_unit_if #(
   parameter int WIDTH = 256
);
   logic             in_valid;
   logic [WIDTH-1:0] Px;
   logic [WIDTH-1:0] Py;
   logic [WIDTH-1:0] Qx;
   logic [WIDTH-1:0] Qy;
   logic             busy;
   logic [WIDTH-1:0] Rx;
   logic [WIDTH-1:0] Ry;
   logic             out_valid;
`ifdef ECC_ADD_ERR_EN
   logic             err;
   modport master (output in_valid, Px, Py, Qx, Qy, input busy, Rx, Ry, out_valid, err);
   modport slave  (input in_valid, Px, Py, Qx, Qy, output busy, Rx, Ry, out_valid, err);
`else
   modport master (output in_valid, Px, Py, Qx, Qy, input busy, Rx, Ry, out_valid);
   modport slave  (input in_valid, Px, Py, Qx, Qy, output busy, Rx, Ry, out_valid);
`endif
endinterface

// File: rtl/ecc_mod_mul.sv
// Serial MSB-first interleaved shift-add multiplier: r = a*b mod p, done pulses WIDTH+1 cycles after start.
// A new start restarts the operation; no backpressure, the caller waits for done.
module ecc_mod_mul #(
   parameter int WIDTH = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] p_i,
   output logic [WIDTH-1:0] r_o,
   output logic             done_o
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
   logic [CW-1:0]    cnt_q;
   logic             run_q, done_q;
   logic [WIDTH:0]   dbl, sum, p1;

   // acc < p keeps both 2*acc and (2*acc mod p) + a below 2p, so one conditional subtract suffices.
   always_comb begin
      p1  = {1'b0, p_i};
      dbl = {acc_q, 1'b0};
      if (dbl >= p1) dbl = dbl - p1;
      sum = dbl + (b_q[WIDTH-1] ? {1'b0, a_q} : '0);
      if (sum >= p1) sum = sum - p1;
      acc_d = sum[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= '0;
            cnt_q <= CW'(WIDTH);
            run_q <= 1'b1;
         end else if (run_q) begin
            if (cnt_q == '0) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end else begin
               acc_q <= acc_d;
               b_q   <= {b_q[WIDTH-2:0], 1'b0};
               cnt_q <= cnt_q - CW'(1);
            end
         end
      end
   end

   assign r_o    = acc_q;
   assign done_o = done_q;
endmodule

// File: rtl/ecc_point_add_unit.sv
// Affine R = P + Q over GF(p) with automatic doubling; variable latency (special cases: 3 cycles), in_valid ignored while busy.
// ECC_ADD_ERR_EN adds an err output that flags out-of-range operands and forces R = (0,0).
module ecc_point_add_unit
   import ecc_pkg::*;
#(
   parameter int               WIDTH   = ECC_WIDTH,
   parameter logic [WIDTH-1:0] FIELD_P = WIDTH'(ECC_FIELD_P),
   parameter logic [WIDTH-1:0] CURVE_A = WIDTH'(ECC_CURVE_A)
) (
   input  logic               clk,
   input  logic               rst_n,
   ecc_point_add_unit_if.slave bus
);
   state_e           state_q;
   logic [WIDTH-1:0] px_q, py_q, qx_q, qy_q, num_q, lam_q, t_q;
   logic [WIDTH-1:0] u_q, v_q, x1_q, x2_q, resx_q, resy_q, rx_q, ry_q;
   logic             dbl_q, ph_q, mst_q, ov_q, busy_q;
   logic [WIDTH-1:0] u_d, v_d, x1_d, x2_d, inv_val, mul_a, mul_b, mul_r;
   logic             inv_fin, mul_done, p_inf, q_inf, eq_x;

   function automatic logic [WIDTH-1:0] add_m(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, FIELD_P}) s = s - {1'b0, FIELD_P};
      return s[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] sub_m(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[WIDTH]) d = d + {1'b0, FIELD_P};
      return d[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] half_m(input logic [WIDTH-1:0] a);
      logic [WIDTH:0] s;
      s = a[0] ? ({1'b0, a} + {1'b0, FIELD_P}) : {1'b0, a};
      return WIDTH'(s >> 1);
   endfunction

   assign p_inf = (px_q == '0) && (py_q == '0);
   assign q_inf = (qx_q == '0) && (qy_q == '0);
   assign eq_x  = (px_q == qx_q);

   // Binary inversion step; odd/odd folds subtract and halve into one cycle so u+v loses a bit every cycle.
   // u or v reaching 0 only happens for garbage operands and ends the loop instead of hanging.
   always_comb begin
      u_d     = u_q;
      v_d     = v_q;
      x1_d    = x1_q;
      x2_d    = x2_q;
      inv_fin = (u_q <= WIDTH'(1)) || (v_q <= WIDTH'(1));
      inv_val = (u_q == WIDTH'(1)) ? x1_q : x2_q;
      if (!u_q[0]) begin
         u_d  = u_q >> 1;
         x1_d = half_m(x1_q);
      end else if (!v_q[0]) begin
         v_d  = v_q >> 1;
         x2_d = half_m(x2_q);
      end else if (u_q >= v_q) begin
         u_d  = (u_q - v_q) >> 1;
         x1_d = half_m(sub_m(x1_q, x2_q));
      end else begin
         v_d  = (v_q - u_q) >> 1;
         x2_d = half_m(sub_m(x2_q, x1_q));
      end
   end

   always_comb begin
      mul_a = lam_q;
      mul_b = lam_q;
      case (state_q)
         S_NUM:   begin mul_a = px_q;  mul_b = px_q; end
         S_LAM:   begin mul_a = num_q; mul_b = t_q;  end
         S_Y3M:   mul_b = sub_m(px_q, resx_q);
         default: ;
      endcase
   end

   ecc_mod_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (mst_q),
      .a_i     (mul_a),
      .b_i     (mul_b),
      .p_i     (FIELD_P),
      .r_o     (mul_r),
      .done_o  (mul_done)
   );

`ifdef ECC_ADD_ERR_EN
   logic oor, err_nx_q, err_q;
   assign oor     = (px_q >= FIELD_P) || (py_q >= FIELD_P) || (qx_q >= FIELD_P) || (qy_q >= FIELD_P);
   assign bus.err = err_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         {px_q, py_q, qx_q, qy_q, num_q, lam_q, t_q} <= '0;
         {u_q, v_q, x1_q, x2_q, resx_q, resy_q, rx_q, ry_q} <= '0;
         {dbl_q, ph_q, mst_q, ov_q, busy_q} <= '0;
`ifdef ECC_ADD_ERR_EN
         err_nx_q <= 1'b0;
         err_q    <= 1'b0;
`endif
      end else begin
         mst_q <= 1'b0;
         case (state_q)
            S_IDLE: if (bus.in_valid) begin
               px_q    <= bus.Px;
               py_q    <= bus.Py;
               qx_q    <= bus.Qx;
               qy_q    <= bus.Qy;
               busy_q  <= 1'b1;
               state_q <= S_CLASS;
            end
            S_CLASS: begin
               state_q <= S_SHORT;
               resx_q  <= '0;
               resy_q  <= '0;
`ifdef ECC_ADD_ERR_EN
               err_nx_q <= oor;
               if (oor) begin
               end else
`endif
               if (p_inf) begin
                  resx_q <= qx_q;
                  resy_q <= qy_q;
               end else if (q_inf) begin
                  resx_q <= px_q;
                  resy_q <= py_q;
               end else if (eq_x && ((py_q != qy_q) || (py_q == '0))) begin
               end else begin
                  dbl_q   <= eq_x;
                  mst_q   <= eq_x;
                  state_q <= S_NUM;
               end
            end
            S_NUM: if (!dbl_q) begin
               num_q   <= sub_m(qy_q, py_q);
               state_q <= S_DEN;
            end else if (mul_done) begin
               num_q   <= add_m(add_m(add_m(mul_r, mul_r), mul_r), CURVE_A);
               state_q <= S_DEN;
            end
            S_DEN: begin
               u_q     <= dbl_q ? add_m(py_q, py_q) : sub_m(qx_q, px_q);
               v_q     <= FIELD_P;
               x1_q    <= WIDTH'(1);
               x2_q    <= '0;
               state_q <= S_INV;
            end
            S_INV: if (inv_fin) begin
               t_q     <= inv_val;
               mst_q   <= 1'b1;
               state_q <= S_LAM;
            end else begin
               u_q  <= u_d;
               v_q  <= v_d;
               x1_q <= x1_d;
               x2_q <= x2_d;
            end
            S_LAM: if (mul_done) begin
               lam_q   <= mul_r;
               mst_q   <= 1'b1;
               state_q <= S_LSQ;
            end
            S_LSQ: if (mul_done) begin
               t_q     <= mul_r;
               ph_q    <= 1'b0;
               state_q <= S_X3;
            end
            S_X3: if (!ph_q) begin
               t_q  <= sub_m(t_q, px_q);
               ph_q <= 1'b1;
            end else begin
               resx_q  <= sub_m(t_q, qx_q);
               mst_q   <= 1'b1;
               state_q <= S_Y3M;
            end
            S_Y3M: if (mul_done) begin
               t_q     <= mul_r;
               state_q <= S_Y3;
            end
            S_Y3: begin
               rx_q    <= resx_q;
               ry_q    <= sub_m(t_q, py_q);
               ov_q    <= 1'b1;
`ifdef ECC_ADD_ERR_EN
               err_q   <= 1'b0;
`endif
               state_q <= S_DONE;
            end
            S_SHORT: begin
               rx_q    <= resx_q;
               ry_q    <= resy_q;
               ov_q    <= 1'b1;
`ifdef ECC_ADD_ERR_EN
               err_q   <= err_nx_q;
`endif
               state_q <= S_DONE;
            end
            default: begin
               ov_q    <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.Rx        = rx_q;
   assign bus.Ry        = ry_q;
   assign bus.out_valid = ov_q;
endmodule
